// File: rtl/aes_seq_pkg.sv
// Shared constants and state encoding for the AES job sequencer.
// Register map, bit positions and key word counts of the AES core port.
package aes_seq_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;

    localparam int CTRL_INIT_BIT     = 0;
    localparam int CTRL_NEXT_BIT     = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int STATUS_VALID_BIT  = 1;
    localparam int CONFIG_ENCDEC_BIT = 0;
    localparam int CONFIG_KEYLEN_BIT = 1;

    localparam int KEY_WORDS_128 = 4;
    localparam int KEY_WORDS_256 = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_CFG,
        ST_WR_KEY,
        ST_INIT,
        ST_POLL_RDY,
        ST_WR_BLK,
        ST_NEXT,
        ST_POLL_VLD,
        ST_RD_RES,
        ST_DONE
    } state_t;

endpackage

// File: rtl/aes_job_sequencer.sv
// Bus master that runs one AES job end to end on the core register port,
// skipping key expansion when the previously expanded key is reused.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int TIMER_W      = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_key,
    input  logic         job_keylen,
    input  logic         job_encdec,
    input  logic [127:0] job_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_error,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    output logic         busy
);

    state_t r_state;
    state_t w_next;

    logic [255:0]       r_key;
    logic               r_keylen;
    logic               r_encdec;
    logic [127:0]       r_blk;
    logic [255:0]       r_cache_key;
    logic               r_cache_keylen;
    logic               r_cache_valid;
    logic [127:0]       r_res;
    logic               r_err;
    logic               r_live;
    logic [2:0]         r_idx;
    logic [TIMER_W-1:0] r_timer;

    logic       w_hit;
    logic       w_key_eq;
    logic       w_timeout;
    logic [2:0] w_key_last;

    assign w_key_eq   = r_keylen ? (r_cache_key == r_key)
                                 : (r_cache_key[255:128] == r_key[255:128]);
    assign w_hit      = r_cache_valid && (r_cache_keylen == r_keylen) && w_key_eq;
    assign w_timeout  = (r_timer == TIMER_W'(POLL_TIMEOUT - 1));
    assign w_key_last = r_keylen ? 3'(KEY_WORDS_256 - 1) : 3'(KEY_WORDS_128 - 1);

    // r_live keeps job_ready low while reset is asserted
    assign job_ready = r_live && (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_DONE);
    assign res_error = res_valid && r_err;
    assign res_data  = r_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cs         = 1'b0;
        we         = 1'b0;
        address    = 8'h00;
        write_data = 32'h0;
        unique case (r_state)
            ST_IDLE: begin
                if (job_valid && r_live) w_next = ST_WR_CFG;
            end
            ST_WR_CFG: begin
                cs = 1'b1;
                we = 1'b1;
                address = ADDR_CONFIG;
                write_data[CONFIG_ENCDEC_BIT] = r_encdec;
                write_data[CONFIG_KEYLEN_BIT] = r_keylen;
                w_next = w_hit ? ST_WR_BLK : ST_WR_KEY;
            end
            ST_WR_KEY: begin
                cs = 1'b1;
                we = 1'b1;
                address = ADDR_KEY0 + {5'b0, r_idx};
                write_data = r_key[{~r_idx, 5'b0} +: 32];
                if (r_idx == w_key_last) w_next = ST_INIT;
            end
            ST_INIT: begin
                cs = 1'b1;
                we = 1'b1;
                address = ADDR_CTRL;
                write_data[CTRL_INIT_BIT] = 1'b1;
                w_next = ST_POLL_RDY;
            end
            ST_POLL_RDY: begin
                cs = 1'b1;
                address = ADDR_STATUS;
                if (read_data[STATUS_READY_BIT]) w_next = ST_WR_BLK;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_WR_BLK: begin
                cs = 1'b1;
                we = 1'b1;
                address = ADDR_BLOCK0 + {6'b0, r_idx[1:0]};
                write_data = r_blk[{~r_idx[1:0], 5'b0} +: 32];
                if (r_idx[1:0] == 2'd3) w_next = ST_NEXT;
            end
            ST_NEXT: begin
                cs = 1'b1;
                we = 1'b1;
                address = ADDR_CTRL;
                write_data[CTRL_NEXT_BIT] = 1'b1;
                w_next = ST_POLL_VLD;
            end
            ST_POLL_VLD: begin
                cs = 1'b1;
                address = ADDR_STATUS;
                if (read_data[STATUS_VALID_BIT]) w_next = ST_RD_RES;
                else if (w_timeout) w_next = ST_DONE;
            end
            ST_RD_RES: begin
                cs = 1'b1;
                address = ADDR_RESULT0 + {6'b0, r_idx[1:0]};
                if (r_idx[1:0] == 2'd3) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key          <= '0;
            r_keylen       <= 1'b0;
            r_encdec       <= 1'b0;
            r_blk          <= '0;
            r_cache_key    <= '0;
            r_cache_keylen <= 1'b0;
            r_cache_valid  <= 1'b0;
            r_res          <= '0;
            r_err          <= 1'b0;
            r_live         <= 1'b0;
            r_idx          <= 3'd0;
            r_timer        <= '0;
        end else begin
            r_live <= 1'b1;
            if (job_ready && job_valid) begin
                r_key    <= job_key;
                r_keylen <= job_keylen;
                r_encdec <= job_encdec;
                r_blk    <= job_block;
                r_err    <= 1'b0;
            end
            if (w_next != r_state) begin
                r_idx <= 3'd0;
            end else if (r_state == ST_WR_KEY || r_state == ST_WR_BLK ||
                         r_state == ST_RD_RES) begin
                r_idx <= r_idx + 3'd1;
            end
            // poll budget restarts whenever a poll state is entered
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state == ST_POLL_RDY || r_state == ST_POLL_VLD) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
            if (r_state == ST_POLL_RDY && read_data[STATUS_READY_BIT]) begin
                r_cache_valid  <= 1'b1;
                r_cache_key    <= r_key;
                r_cache_keylen <= r_keylen;
            end
            if ((r_state == ST_POLL_RDY || r_state == ST_POLL_VLD) &&
                w_next == ST_DONE) begin
                r_err         <= 1'b1;
                r_res         <= '0;
                r_cache_valid <= 1'b0;
            end
            if (r_state == ST_RD_RES) begin
                r_res[{~r_idx[1:0], 5'b0} +: 32] <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Randomized bench for aes_job_sequencer with a stub AES core and a
// job-level reference model (result, key cache, bus access counts).
module tb_aes_job_sequencer;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [255:0] job_key = '0;
    logic         job_keylen = 1'b0;
    logic         job_encdec = 1'b0;
    logic [127:0] job_block = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [127:0] res_data;
    logic         res_error;
    logic         cs;
    logic         we;
    logic [7:0]   address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         busy;

    always #5 clk = ~clk;

    aes_job_sequencer #(.POLL_TIMEOUT(TO), .TIMER_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_key(job_key), .job_keylen(job_keylen),
        .job_encdec(job_encdec), .job_block(job_block),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_error(res_error),
        .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data),
        .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // stand-in cipher: position sensitive, depends on key, keylen and direction
    function automatic logic [127:0] fake(input logic [255:0] k, input logic kl,
                                          input logic ed, input logic [127:0] b);
        logic [127:0] r;
        r = b ^ k[255:128];
        if (kl) r = r ^ k[127:0];
        r = r ^ (ed ? {4{32'hA5A5A5A5}} : {4{32'h3C3C3C3C}});
        return r;
    endfunction

    // stub core
    bit           hang = 1'b0;
    int           lat_r = 0;
    int           lat_v = 0;
    logic [255:0] c_key = '0;
    logic [255:0] c_ekey = '0;
    logic         c_ekl = 1'b0;
    logic [127:0] c_blk = '0;
    logic [127:0] c_res = '0;
    logic [1:0]   c_cfg = '0;
    int           c_rcnt = 0;
    int           c_vcnt = 0;

    always @(posedge clk) begin
        if (c_rcnt > 0) c_rcnt <= c_rcnt - 1;
        if (c_vcnt > 0) c_vcnt <= c_vcnt - 1;
        if (cs && we) begin
            if (address == 8'h0a) c_cfg <= write_data[1:0];
            else if (address[7:3] == 5'b00010)
                c_key[{~address[2:0], 5'b0} +: 32] <= write_data;
            else if (address[7:2] == 6'b001000)
                c_blk[{~address[1:0], 5'b0} +: 32] <= write_data;
            else if (address == 8'h08 && write_data[0]) begin
                c_ekey <= c_key;
                c_ekl  <= c_cfg[1];
                c_rcnt <= lat_r;
            end else if (address == 8'h08 && write_data[1]) begin
                c_res  <= fake(c_ekey, c_ekl, c_cfg[0], c_blk);
                c_vcnt <= lat_v;
            end
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (cs && !we && address == 8'h09)
            read_data = {30'b0, (c_vcnt == 0) && !hang, c_rcnt == 0};
        else if (cs && !we && address[7:2] == 6'b001100)
            read_data = c_res[{~address[1:0], 5'b0} +: 32];
    end

    // reference model
    typedef struct {
        logic [127:0] res;
        logic         err;
        int           keyw;
        int           initw;
        logic [31:0]  cfg;
        int           acc;
        logic [255:0] key;
    } exp_t;

    exp_t         exp_q[$];
    bit           m_cv = 1'b0;
    logic [255:0] m_ck = '0;
    logic         m_ckl = 1'b0;

    int          last_keyw = -1;
    int          last_initw = -1;
    int          last_acc = -1;
    logic [31:0] last_cfg = '0;

    // compare process
    initial begin
        int m_keyw;
        int m_initw;
        int m_acc;
        logic [31:0] m_cfg;
        bit seen;
        logic [127:0] held;
        exp_t e;
        m_keyw = 0; m_initw = 0; m_acc = 0; m_cfg = '0; seen = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_keyw = 0; m_initw = 0; m_acc = 0; m_cfg = '0; seen = 0;
            end else begin
                chk("ready_only_idle", 128'(job_ready & busy), 128'(0));
                if (!cs) chk("bus_idle", 128'({we, address, write_data}), 128'(0));
                else m_acc++;
                if (cs && we) begin
                    if (address[7:3] == 5'b00010) begin
                        m_keyw++;
                        if (exp_q.size() > 0)
                            chk("key_word", 128'(write_data),
                                128'(exp_q[0].key[{~address[2:0], 5'b0} +: 32]));
                    end
                    if (address == 8'h08 && write_data == 32'h1) m_initw++;
                    if (address == 8'h0a) m_cfg = write_data;
                end
                if (res_valid && !seen) begin
                    seen = 1;
                    held = res_data;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_data", res_data, e.res);
                        chk("res_error", 128'(res_error), 128'(e.err));
                        chk("key_writes", 128'(m_keyw), 128'(e.keyw));
                        chk("init_writes", 128'(m_initw), 128'(e.initw));
                        chk("config", 128'(m_cfg), 128'(e.cfg));
                        chk("access_cycles", 128'(m_acc), 128'(e.acc));
                    end
                    last_keyw = m_keyw; last_initw = m_initw;
                    last_acc = m_acc; last_cfg = m_cfg;
                    m_keyw = 0; m_initw = 0; m_acc = 0;
                end else if (res_valid) begin
                    chk("res_hold", res_data, held);
                    chk("ready_in_done", 128'(job_ready), 128'(0));
                end
                if (!res_valid) seen = 0;
            end
        end
    end

    task automatic run_job(input logic [255:0] k, input logic kl, input logic ed,
                           input logic [127:0] b, input int hold,
                           output logic [127:0] got);
        exp_t e;
        bit hit;
        int n;
        hit = m_cv && (m_ckl == kl) &&
              (kl ? (m_ck == k) : (m_ck[255:128] == k[255:128]));
        e.res   = hang ? 128'h0 : fake(k, kl, ed, b);
        e.err   = hang;
        e.keyw  = hit ? 0 : (kl ? 8 : 4);
        e.initw = hit ? 0 : 1;
        e.cfg   = {30'b0, kl, ed};
        e.acc   = 1 + (hit ? 0 : e.keyw + 1 + lat_r + 1) + 4 + 1 +
                  (hang ? TO : lat_v + 1 + 4);
        e.key   = k;
        @(posedge clk); #1;
        job_key = k; job_keylen = kl; job_encdec = ed; job_block = b;
        job_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!job_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept", 128'(job_ready), 128'(1));
        exp_q.push_back(e);
        if (hang) m_cv = 1'b0;
        else if (!hit) begin m_cv = 1'b1; m_ck = k; m_ckl = kl; end
        @(posedge clk); #1;
        job_valid  = 1'b0;
        job_key    = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        job_block  = {$urandom, $urandom, $urandom, $urandom};
        job_keylen = 1'($urandom_range(0, 1));
        job_encdec = 1'($urandom_range(0, 1));
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 3000) begin @(negedge clk); n++; end
        chk("result_wait", 128'(res_valid), 128'(1));
        got = res_data;
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        @(negedge clk);
        chk("done_exit", 128'({res_valid, job_ready}), 128'(2'b01));
    endtask

    localparam logic [255:0] K128 =
        256'h000102030405060708090a0b0c0d0e0f_deadbeefcafef00d0123456789abcdef;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] BLK = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [127:0] got;
        logic [127:0] r1;
        logic [255:0] pool[3];
        int n;
        #2;
        chk("reset_data", res_data, 128'h0);
        chk("reset_ctl", 128'({job_ready, res_valid, res_error, cs, we,
                               address, write_data, busy}), 128'(0));
        chk("model_pin_zero", fake('0, 1'b0, 1'b1, '0), {4{32'hA5A5A5A5}});
        repeat (2) @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("ready_after_reset", 128'(job_ready), 128'(1));

        run_job(K128, 1'b0, 1'b1, BLK, 0, r1);
        chk("aes128_enc_lit", r1, 128'ha5b58595e5f5c5d52535051565754555);
        chk("aes128_keyw_lit", 128'(last_keyw), 128'(4));

        run_job(K128, 1'b0, 1'b0, r1, 0, got);
        chk("hit_keyw_lit", 128'(last_keyw), 128'(0));
        chk("hit_init_lit", 128'(last_initw), 128'(0));
        chk("hit_acc_lit", 128'(last_acc), 128'(11));

        run_job(K256, 1'b1, 1'b1, BLK, 0, got);
        chk("aes256_lit", got, 128'hb5a49786f1e0d3c23d2c1f0e79685b4a);
        chk("aes256_keyw_lit", 128'(last_keyw), 128'(8));
        chk("aes256_cfg_lit", 128'(last_cfg), 128'(3));
        chk("aes256_acc_lit", 128'(last_acc), 128'(21));

        hang = 1'b1;
        run_job(K128, 1'b0, 1'b1, BLK, 0, got);
        chk("timeout_data_lit", got, 128'h0);
        chk("timeout_acc_lit", 128'(last_acc), 128'(28));
        hang = 1'b0;
        run_job(K128, 1'b0, 1'b1, BLK, 0, got);
        chk("reexpand_keyw_lit", 128'(last_keyw), 128'(4));

        run_job(K128, 1'b0, 1'b1, BLK, 10, got);

        // reset in the middle of key programming
        @(posedge clk); #1;
        job_key = K256; job_keylen = 1'b1; job_encdec = 1'b1; job_block = BLK;
        job_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(cs && we && address == 8'h11) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("reached_wr_key", 128'(cs && we && address == 8'h11), 128'(1));
        #1 reset_n = 1'b0; job_valid = 1'b0;
        #1;
        chk("midreset_data", res_data, 128'h0);
        chk("midreset_ctl", 128'({job_ready, res_valid, res_error, cs, we,
                                  address, write_data, busy}), 128'(0));
        m_cv = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk); #1 reset_n = 1'b1;
        run_job(K128, 1'b0, 1'b1, BLK, 0, got);
        chk("postreset_keyw_lit", 128'(last_keyw), 128'(4));

        for (int i = 0; i < 3; i++)
            pool[i] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < 40; j++) begin
            lat_r = $urandom_range(0, 4);
            lat_v = $urandom_range(0, 4);
            hang  = ($urandom_range(0, 7) == 0);
            run_job(pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 3), got);
        end
        hang = 1'b0;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_job_sequencer.md
Name: aes_job_sequencer

Overview:
- Autonomous master for the AES core's 8-bit-address / 32-bit-data register port (cs, we, address, write_data, read_data).
- Accepts one encryption/decryption job per valid/ready handshake and programs key, config and block registers in order.
- Triggers init/next, polls status, reads back the 128-bit result and presents it on a valid/ready result port.
- Skips key expansion when key and keylen equal the last successfully expanded key.

Parameters:
- POLL_TIMEOUT, 1024, max status-poll cycles per wait before the job aborts with error.
- TIMER_W, 11, poll counter width; must satisfy 2^TIMER_W > POLL_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  sequencer can accept a job
- job_key  in  256  key; [255:224] goes to word 0
- job_keylen  in  1  0 = AES-128 (uses job_key[255:128]), 1 = AES-256
- job_encdec  in  1  1 = encrypt, 0 = decrypt
- job_block  in  128  input block; [127:96] goes to word 0
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  128  result; word 0 lands in [127:96]
- res_error  out  1  poll timeout occurred, res_data forced to 0
- cs  out  1  core select
- we  out  1  core write enable
- address  out  8  core register address
- write_data  out  32  core write data
- read_data  in  32  core read data; combinational, valid in the same cycle as cs=1, we=0
- busy  out  1  high in every state except IDLE

Behaviour:
- Register map constants:
  - CTRL 0x08: bit0 init, bit1 next.
  - STATUS 0x09: bit0 ready, bit1 valid.
  - CONFIG 0x0a: bit0 encdec, bit1 keylen.
  - KEY0..7 0x10-0x17; BLOCK0..3 0x20-0x23; RESULT0..3 0x30-0x33.
- Reset:
  - All outputs 0; state IDLE.
  - Key cache invalid; cached key and keylen cleared.
  - Reset mid-job abandons the job silently with no result.
- Bus ops are one per cycle. cs=1 only in cycles that perform an access; otherwise cs, we, address and write_data are 0.
- Job acceptance:
  - job_ready=1 only in IDLE.
  - On job_valid & job_ready, latch key, keylen, encdec and block into internal registers.
  - Job inputs may change after acceptance.
- FSM sequence: IDLE -> WR_CFG -> [hit ? WR_BLK : WR_KEY] ...
  - WR_CFG: one write to 0x0a of {30'b0, keylen, encdec}.
  - Cache hit: cache valid, keylen equal, and the relevant key bits equal (128 bits for AES-128, 256 for AES-256).
  - WR_KEY: write words 0..3 (AES-128) or 0..7 (AES-256) at 0x10+i.
  - INIT: write 0x08 = 0x1.
  - POLL_RDY: read 0x09 every cycle until bit0=1. The first poll is in the cycle after INIT. On success, set cache valid and store key/keylen, then go to WR_BLK.
  - WR_BLK: 4 writes, 0x20..0x23.
  - NEXT: write 0x08 = 0x2.
  - POLL_VLD: read 0x09 until bit1=1.
  - RD_RES: 4 reads, 0x30..0x33, captured into res_data.
  - DONE: res_valid=1, held with res_data stable until res_ready. The cycle after the handshake returns to IDLE, with res_valid=0.
- Timeout:
  - The poll counter resets on entry to each POLL state.
  - If POLL_TIMEOUT reads fail, go to DONE with res_error=1 and res_data=0, and invalidate the cache.
  - res_error clears with res_valid.
- Bus cycle counts:
  - AES-256 miss, zero poll wait: 1+8+1+1+4+1+1+4 = 21 access cycles before DONE.
  - Hit: 1+4+1+1+4 = 11 access cycles.
- A keylen change always forces a miss, even when the upper 128 key bits match.
- No back-to-back job acceptance while res_valid is pending; job_ready stays 0.

Decomposition:
- Package aes_seq_pkg holds:
  - Register address constants and CTRL/STATUS/CONFIG bit indices.
  - The FSM state enum.
  - The word-count constants KEY_WORDS_128=4 and KEY_WORDS_256=8.
- No sub-module is required. A word index counter (3 bits) is shared by the WR_KEY, WR_BLK and RD_RES states.

Test Plan:
- AES-128 encrypt, key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff, real core attached -> res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_error=0, exactly 4 key writes observed.
- Same key repeated with decrypt (encdec=0) of 69c4e0d86a7b0430d8cdb78070b4c55a -> res_data 00112233445566778899aabbccddeeff; zero writes to 0x10-0x17 and no init write (cache hit).
- AES-256 key 000102...1f, block 00112233445566778899aabbccddeeff, encrypt -> 8e a2b7ca516745bfeafc49904b496089 (8ea2b7ca516745bfeafc49904b496089); 8 key writes; CONFIG write = 0x3.
- Stub core whose status bit1 never sets, POLL_TIMEOUT=16 -> res_valid with res_error=1, res_data=0 after 16 polls; the next identical job re-expands the key (cache invalidated).
- res_ready held 0 for 10 cycles in DONE -> res_valid and res_data stable, job_ready=0 throughout; one cycle after the handshake, job_ready=1.
- reset_n pulsed low during WR_KEY -> all outputs 0 immediately; after release the next job performs a full key write (cache invalid).
